// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one
// shared req/ack memory port, with a sticky illegal-instruction trap and retire counter.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_out,
  output logic [31:0]       alu_result,
  output logic              trap,
  output logic [CNT_W-1:0]  instr_retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr, r_addr, r_wdata;
  logic        r_req, r_we;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_gpr [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dst;
  logic [31:0] w_imm_s, w_imm_z, w_alu, w_pc_next, w_wbdata;
  logic        w_ack, w_legal, w_retire;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_imm_s = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm_z = {16'h0000, r_ir[15:0]};
  assign w_ack   = r_req & mem_ack;
  assign w_dst   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wbdata = (w_op == OP_LW) ? r_mdr : r_aluout;

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: w_legal = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                          (w_funct == FN_OR)  || (w_funct == FN_SLT) || (w_funct == FN_JR);
      OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_alu     = r_a + w_imm_s;
    w_retire  = 1'b0;
    case (r_state)
      S_FETCH: if (w_ack) begin
        w_next    = S_DECODE;
        w_pc_next = r_pc + 32'd4;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        w_next = S_TRAP;
        case (w_op)
          OP_RTYPE: begin
            w_next = S_WB;
            case (w_funct)
              FN_ADD: w_alu = r_a + r_b;
              FN_SUB: w_alu = r_a - r_b;
              FN_AND: w_alu = r_a & r_b;
              FN_OR:  w_alu = r_a | r_b;
              FN_SLT: w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
              FN_JR: begin
                if (r_a[1:0] != 2'b00) begin
                  w_next = S_TRAP;
                end else begin
                  w_next    = S_FETCH;
                  w_pc_next = r_a;
                  w_retire  = 1'b1;
                end
              end
              default: w_next = S_TRAP;
            endcase
          end
          OP_ADDI: w_next = S_WB;
          OP_ORI: begin
            w_alu  = r_a | w_imm_z;
            w_next = S_WB;
          end
          OP_LW, OP_SW: w_next = (w_alu[1:0] != 2'b00) ? S_TRAP : S_MEM;
          OP_BEQ: begin
            w_alu    = r_a - r_b;
            w_next   = S_FETCH;
            w_retire = 1'b1;
            if (r_a == r_b) w_pc_next = r_pc + {w_imm_s[29:0], 2'b00};
          end
          OP_J: begin
            w_next    = S_FETCH;
            w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            w_retire  = 1'b1;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: if (w_ack) begin
        w_next   = (w_op == OP_SW) ? S_FETCH : S_WB;
        w_retire = (w_op == OP_SW);
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // Bus outputs are reloaded only when no transfer is outstanding (or it completes this
  // cycle), so a request launched on entering FETCH/MEM stays frozen until its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (r_state == S_FETCH && w_ack) r_ir <= mem_rdata;
      if (r_state == S_DECODE) begin
        r_a <= r_gpr[w_rs];
        r_b <= r_gpr[w_rt];
      end
      if (r_state == S_EXEC) r_aluout <= w_alu;
      if (r_state == S_MEM && w_ack) r_mdr <= mem_rdata;
      if (!r_req || mem_ack) begin
        r_req   <= (w_next == S_FETCH) || (w_next == S_MEM);
        r_we    <= (w_next == S_MEM) && (w_op == OP_SW);
        r_addr  <= (w_next == S_MEM) ? w_alu : w_pc_next;
        r_wdata <= r_b;
      end
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else if (r_state == S_WB && w_dst != 5'd0) begin
      r_gpr[w_dst] <= w_wbdata;
    end
  end

  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr[ADDR_W-1:0];
  assign mem_wdata     = r_wdata;
  assign pc_out        = r_pc;
  assign alu_result    = r_aluout;
  assign trap          = (r_state == S_TRAP);
  assign instr_retired = r_cnt;

endmodule
